muldiv_sequencer: RTL and testbench

Iterative multiply/divide sequencer and HI/LO register file for the pipelined MIPS core. It executes MULT, MULTU, DIV and DIVU in the shared shift-add/restoring datapath over multiple cycles, and handles MTHI/MTLO in a single cycle. It sits beside the EX-stage ALU. It stalls the pipeline when an MFHI/MFLO read arrives while an operation is still in flight.

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// muldiv_pkg : op encodings, FSM states and the sign helper for muldiv_sequencer
// Revision   : 1.0
// ============================================================================
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  // Width the sign helper works in; must cover the 2*WIDTH product.
  localparam int NEG_W = 128;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // Conditional two's-complement negate; with en = sign bit it yields |v|.
  function automatic logic [NEG_W-1:0] cond_neg(input logic [NEG_W-1:0] v,
                                                input logic             en);
    cond_neg = en ? (~v + NEG_W'(1)) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// muldiv_sequencer : iterative MULT/MULTU/DIV/DIVU engine plus HI/LO registers.
// Optional macro   : MULDIV_EARLY_EXIT_EN (zero-operand shortcut straight to FIX)
// Revision         : 1.0
// ============================================================================
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mf_req,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int DW = 2 * WIDTH;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic [DW-1:0]    acc;
  logic [WIDTH-1:0] opnd;
  logic             is_div;
  logic             res_neg;
  logic             rem_neg;

  logic             is_mult_op;
  logic             is_div_op;
  logic             is_signed_op;
  logic             a_neg;
  logic             b_neg;
  logic             b_zero;
  logic             go;
  logic             early_exit;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH:0]   div_diff;
  logic [DW-1:0]    prod_fixed;
  logic [WIDTH-1:0] quo_fixed;
  logic [WIDTH-1:0] rem_fixed;

  // ---------------------------------------------------------------- decode
  assign is_mult_op   = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div_op    = (op == OP_DIV)  || (op == OP_DIVU);
  assign is_signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg        = is_signed_op & a[WIDTH-1];
  assign b_neg        = is_signed_op & b[WIDTH-1];
  assign b_zero       = (b == '0);
  assign go           = start && (state == S_IDLE) && (is_mult_op || is_div_op);

  assign a_mag = WIDTH'(cond_neg(NEG_W'(a), a_neg));
  assign b_mag = WIDTH'(cond_neg(NEG_W'(b), b_neg));

`ifdef MULDIV_EARLY_EXIT_EN
  assign early_exit = (is_mult_op && ((a == '0) || b_zero)) || (is_div_op && b_zero);
`else
  assign early_exit = 1'b0;
`endif

  // ---------------------------------------------------------------- iteration step
  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
  // Divide:   acc = {partial remainder, remaining dividend bits / quotient bits}.
  assign mul_sum   = {1'b0, acc[DW-1:WIDTH]} + {1'b0, opnd};
  assign div_trial = acc[DW-1:WIDTH-1];
  assign div_diff  = div_trial - {1'b0, opnd};

  assign prod_fixed = DW'(cond_neg(NEG_W'(acc), res_neg));
  assign quo_fixed  = WIDTH'(cond_neg(NEG_W'(acc[WIDTH-1:0]), res_neg));
  assign rem_fixed  = WIDTH'(cond_neg(NEG_W'(acc[DW-1:WIDTH]), rem_neg));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) begin
          state_next = early_exit ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (count == '0) begin
          state_next = S_FIX;
        end
      end
      S_FIX: begin
        busy       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign stall = busy & mf_req;

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count   <= '0;
      acc     <= '0;
      opnd    <= '0;
      is_div  <= 1'b0;
      res_neg <= 1'b0;
      rem_neg <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            count   <= CNT_W'(WIDTH - 1);
            is_div  <= is_div_op;
            // A zero divisor must leave the quotient as all-ones, never negated.
            res_neg <= (a_neg ^ b_neg) && !(is_div_op && b_zero);
            rem_neg <= is_div_op && a_neg;
            opnd    <= is_div_op ? b_mag : a_mag;
            if (early_exit) begin
              acc <= is_div_op ? {a_mag, {WIDTH{1'b1}}} : '0;
            end else begin
              acc <= {{WIDTH{1'b0}}, (is_div_op ? a_mag : b_mag)};
            end
          end else if (start && (op == OP_MTHI)) begin
            hi <= a;
          end else if (start && (op == OP_MTLO)) begin
            lo <= a;
          end
        end
        S_CALC: begin
          if (count != '0) begin
            count <= count - CNT_W'(1);
          end
          if (is_div) begin
            if (!div_diff[WIDTH]) begin
              acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
              acc <= {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
          end else if (acc[0]) begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end else begin
            acc <= {1'b0, acc[DW-1:1]};
          end
        end
        S_FIX: begin
          done <= 1'b1;
          if (is_div) begin
            lo <= quo_fixed;
            hi <= rem_fixed;
          end else begin
            {hi, lo} <= prod_fixed;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// Scoreboard bench for muldiv_sequencer: directed ops push expected HI/LO and
// completion cycle; a monitor pops and compares on every done pulse.
module tb_muldiv_sequencer;

  localparam int W = 32;
`ifdef MULDIV_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int FULL_LAT = W + 1;
  localparam int ZERO_LAT = EARLY ? 1 : FULL_LAT;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         mf_req;
  logic         busy;
  logic         stall;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .mf_req (mf_req),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int unsigned  at;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending op", cyc);
      end else begin
        e = sb.pop_front();
        check({e.name, "_hi"}, hi, e.hi);
        check({e.name, "_lo"}, lo, e.lo);
        check({e.name, "_cycle"}, cyc, e.at);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input bit push, input logic [W-1:0] eh, input logic [W-1:0] el,
                       input int lat, input string name, output int unsigned t);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1 t = cyc;
    if (push) sb.push_back('{eh, el, t + lat, name});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results pending expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Full-latency op: busy (and stall when mf_req) high for W+1 cycles, then low.
  task automatic busy_window(input bit mreq, input bit poke);
    for (int k = 0; k <= W; k++) begin
      if (k > 0) @(negedge clk);
      if (poke && k == 10) begin
        start = 1'b1;
        op    = 3'b011;
        a     = 32'd1;
        b     = 32'd1;
      end
      if (poke && k == 11) start = 1'b0;
      check("busy_in_flight", busy, 1);
      check("stall_in_flight", stall, mreq);
    end
    @(negedge clk);
    check("busy_done_cycle", busy, 0);
    check("stall_done_cycle", stall, 0);
  endtask

  initial begin : timeout
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int unsigned t;
    rst_n  = 1'b0;
    start  = 1'b0;
    op     = 3'b000;
    a      = '0;
    b      = '0;
    mf_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(3'b000, 32'hFFFF_FFFD, 32'd5, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, FULL_LAT, "mult_m3x5", t);
    busy_window(1'b0, 1'b0);
    // New op sampled in the done cycle.
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 32'h0000_0001, FULL_LAT, "multu_max", t);
    drain();

    issue(3'b010, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, FULL_LAT, "div_m7d2", t);
    drain();
    issue(3'b011, 32'd100, 32'd0, 1, 32'd100, 32'hFFFF_FFFF, ZERO_LAT, "divu_by0", t);
    drain();
    issue(3'b010, 32'hFFFF_FFFB, 32'd0, 1, 32'hFFFF_FFFB, 32'hFFFF_FFFF, ZERO_LAT, "div_neg_by0", t);
    drain();
    issue(3'b011, 32'hFFFF_FFFF, 32'd16, 1, 32'h0000_000F, 32'h0FFF_FFFF, FULL_LAT, "divu_max_d16", t);
    drain();
    issue(3'b000, 32'd0, 32'hFFFF_FFF7, 1, 32'd0, 32'd0, ZERO_LAT, "mult_zero", t);
    drain();
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, 32'h8000_0000, FULL_LAT, "div_ovf", t);
    drain();

    issue(3'b100, 32'h0000_1234, 32'd0, 0, '0, '0, 0, "mthi", t);
    check("mthi_hi", hi, 32'h0000_1234);
    check("mthi_lo", lo, 32'h8000_0000);
    check("mthi_done", done, 0);
    check("mthi_busy", busy, 0);
    issue(3'b101, 32'h0000_ABCD, 32'd0, 0, '0, '0, 0, "mtlo", t);
    check("mtlo_hi", hi, 32'h0000_1234);
    check("mtlo_lo", lo, 32'h0000_ABCD);
    issue(3'b110, 32'hDEAD_BEEF, 32'd3, 0, '0, '0, 0, "nop", t);
    check("nop_hi", hi, 32'h0000_1234);
    check("nop_lo", lo, 32'h0000_ABCD);
    check("nop_busy", busy, 0);

    mf_req = 1'b1;
    issue(3'b000, 32'd7, 32'd6, 1, 32'd0, 32'h0000_002A, FULL_LAT, "mult_7x6_stall", t);
    busy_window(1'b1, 1'b1);
    mf_req = 1'b0;
    drain();

    // Abort a divide mid-flight with reset.
    issue(3'b010, 32'hFFFF_FF9C, 32'd7, 0, '0, '0, 0, "div_abort", t);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    check("abort_done", done, 0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_late_hi", hi, 0);
    check("abort_late_lo", lo, 0);
    check("abort_late_busy", busy, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
